// File: rtl/gbt_rx_frame_monitor_pkg.sv
// Shared types and frame field positions for the GBT RX frame monitor.
// Frame layout: [83:80] IC/EC, [79:72] sequence counter, [71:0] payload.
package gbt_rx_frame_monitor_pkg;

    typedef enum logic [1:0] {
        LNK_UNLOCKED = 2'd0,
        LNK_HUNT     = 2'd1,
        LNK_LOCKED   = 2'd2
    } t_gbt_link_state;

    localparam int GBT_FRAME_W   = 84;
    localparam int GBT_SEQ_MSB   = 79;
    localparam int GBT_SEQ_LSB   = 72;
    localparam int GBT_SEQ_W     = GBT_SEQ_MSB - GBT_SEQ_LSB + 1;
    localparam int GBT_PAYLOAD_W = 72;

    // The 8-bit counter wraps 8'hFF -> 8'h00, which is a legal successor.
    function automatic logic [GBT_SEQ_W-1:0] seq_next(input logic [GBT_SEQ_W-1:0] i_seq);
        return i_seq + 1'b1;
    endfunction

endpackage

// File: rtl/gbt_seq_checker.sv
// Holds the expected sequence number and flags whether the current frame matches it.
// Every accepted frame, good or bad, reloads the expectation to its own seq + 1.
module gbt_seq_checker
    import gbt_rx_frame_monitor_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_act,
    input  logic [GBT_SEQ_W-1:0] i_seq,
    output logic                 o_good
);

    logic [GBT_SEQ_W-1:0] r_exp_seq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp_seq <= '0;
        end else if (i_frame_act) begin
            r_exp_seq <= seq_next(i_seq);
        end
    end

    assign o_good = (i_seq == r_exp_seq);

endmodule

// File: rtl/gbt_rx_frame_monitor.sv
// GBT RX frame monitor: sequence checking, link lock FSM, payload forwarding while
// locked, and a saturating sequence-error counter.
module gbt_rx_frame_monitor
    import gbt_rx_frame_monitor_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned ERR_W    = 16
) (
    input  logic                     clk_ik,
    input  logic                     rstn_ir,
    input  logic                     gbt_rx_ready_i,
    input  logic                     frame_valid_i,
    input  logic [GBT_FRAME_W-1:0]   frame_i,
    input  logic                     err_clear_i,
    output logic [GBT_PAYLOAD_W-1:0] payload_o,
    output logic                     payload_valid_o,
    output logic [3:0]               icec_o,
    output logic [1:0]               link_state_o,
    output logic                     locked_o,
    output logic                     seq_err_o,
    output logic [ERR_W-1:0]         err_cnt_o
);

    localparam logic [7:0] LP_LOCK = 8'(LOCK_CNT);
    localparam logic [7:0] LP_LOSS = 8'(LOSS_CNT);

    t_gbt_link_state            r_state, w_state_nxt;
    logic [7:0]                 r_good_cnt, w_good_cnt_nxt;
    logic [7:0]                 r_bad_cnt, w_bad_cnt_nxt;
    logic [GBT_PAYLOAD_W-1:0]   r_payload;
    logic [3:0]                 r_icec;
    logic                       r_payload_vld;
    logic                       r_seq_err;
    logic                       r_locked;
    logic [ERR_W-1:0]           r_err_cnt;

    logic                       w_frame_act;
    logic                       w_good;
    logic                       w_accept;
    logic                       w_seq_err;
    logic [GBT_SEQ_W-1:0]       w_seq;

    // A ready drop suppresses the frame entirely, so it never reaches the checker.
    assign w_frame_act = frame_valid_i && gbt_rx_ready_i && (r_state != LNK_UNLOCKED);
    assign w_seq       = frame_i[GBT_SEQ_MSB:GBT_SEQ_LSB];

    gbt_seq_checker u_seq_checker (
        .i_clk       (clk_ik),
        .i_rst_n     (rstn_ir),
        .i_frame_act (w_frame_act),
        .i_seq       (w_seq),
        .o_good      (w_good)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        w_accept       = 1'b0;
        w_seq_err      = 1'b0;
        case (r_state)
            LNK_UNLOCKED: begin
                if (gbt_rx_ready_i) begin
                    w_state_nxt = LNK_HUNT;
                end
            end
            LNK_HUNT: begin
                if (w_frame_act) begin
                    // good_cnt==0 marks the first frame of a hunt, which only seeds the checker
                    if ((r_good_cnt != 8'd0) && w_good) begin
                        w_good_cnt_nxt = r_good_cnt + 8'd1;
                    end else begin
                        w_good_cnt_nxt = 8'd1;
                    end
                    if (w_good_cnt_nxt == LP_LOCK) begin
                        w_state_nxt    = LNK_LOCKED;
                        w_good_cnt_nxt = 8'd0;
                        w_bad_cnt_nxt  = 8'd0;
                    end
                end
            end
            LNK_LOCKED: begin
                if (w_frame_act) begin
                    if (w_good) begin
                        w_accept      = 1'b1;
                        w_bad_cnt_nxt = 8'd0;
                    end else begin
                        w_seq_err     = 1'b1;
                        w_bad_cnt_nxt = r_bad_cnt + 8'd1;
                        if (w_bad_cnt_nxt == LP_LOSS) begin
                            w_state_nxt    = LNK_HUNT;
                            w_bad_cnt_nxt  = 8'd0;
                            w_good_cnt_nxt = 8'd0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = LNK_UNLOCKED;
            end
        endcase
        if (!gbt_rx_ready_i) begin
            w_state_nxt    = LNK_UNLOCKED;
            w_good_cnt_nxt = 8'd0;
            w_bad_cnt_nxt  = 8'd0;
        end
    end

    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            r_state       <= LNK_UNLOCKED;
            r_good_cnt    <= '0;
            r_bad_cnt     <= '0;
            r_locked      <= 1'b0;
            r_payload_vld <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_good_cnt    <= w_good_cnt_nxt;
            r_bad_cnt     <= w_bad_cnt_nxt;
            r_locked      <= (w_state_nxt == LNK_LOCKED);
            r_payload_vld <= w_accept;
            r_seq_err     <= w_seq_err;
        end
    end

    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            r_payload <= '0;
            r_icec    <= '0;
        end else if (w_accept) begin
            r_payload <= frame_i[GBT_PAYLOAD_W-1:0];
            r_icec    <= frame_i[GBT_FRAME_W-1:GBT_SEQ_MSB+1];
        end
    end

    // A clear coinciding with an error leaves that error counted.
    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            r_err_cnt <= '0;
        end else if (err_clear_i) begin
            r_err_cnt <= w_seq_err ? ERR_W'(1) : '0;
        end else if (w_seq_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign payload_o       = r_payload;
    assign payload_valid_o = r_payload_vld;
    assign icec_o          = r_icec;
    assign link_state_o    = r_state;
    assign locked_o        = r_locked;
    assign seq_err_o       = r_seq_err;
    assign err_cnt_o       = r_err_cnt;

endmodule

// File: tb/tb_gbt_rx_frame_monitor.sv
// Scoreboard bench for gbt_rx_frame_monitor: stimulus pushes expected payloads,
// a monitor pops them on every payload_valid_o strobe.
module tb_gbt_rx_frame_monitor;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rdy, fv, clr;
    logic [83:0] frame;
    logic [71:0] payload_o;
    logic        payload_valid_o, locked_o, seq_err_o;
    logic [3:0]  icec_o;
    logic [1:0]  link_state_o;
    logic [15:0] err_cnt_o;

    logic        s_rdy, s_fv, s_clr;
    logic [83:0] s_frame;
    logic [71:0] s_payload;
    logic        s_pvld, s_locked, s_seq_err;
    logic [3:0]  s_icec;
    logic [1:0]  s_state;
    logic [2:0]  s_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          seen_err = 0;
    logic [75:0] exp_q[$];
    logic [75:0] e;
    logic [7:0]  sx;

    always #5 clk = ~clk;

    gbt_rx_frame_monitor u_dut (
        .clk_ik          (clk),
        .rstn_ir         (rstn),
        .gbt_rx_ready_i  (rdy),
        .frame_valid_i   (fv),
        .frame_i         (frame),
        .err_clear_i     (clr),
        .payload_o       (payload_o),
        .payload_valid_o (payload_valid_o),
        .icec_o          (icec_o),
        .link_state_o    (link_state_o),
        .locked_o        (locked_o),
        .seq_err_o       (seq_err_o),
        .err_cnt_o       (err_cnt_o)
    );

    gbt_rx_frame_monitor #(.LOCK_CNT(2), .LOSS_CNT(4), .ERR_W(3)) u_sat (
        .clk_ik          (clk),
        .rstn_ir         (rstn),
        .gbt_rx_ready_i  (s_rdy),
        .frame_valid_i   (s_fv),
        .frame_i         (s_frame),
        .err_clear_i     (s_clr),
        .payload_o       (s_payload),
        .payload_valid_o (s_pvld),
        .icec_o          (s_icec),
        .link_state_o    (s_state),
        .locked_o        (s_locked),
        .seq_err_o       (s_seq_err),
        .err_cnt_o       (s_err)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pl(input logic [7:0] s);
        return {8'h5A, 56'h0, s};
    endfunction

    task automatic cyc(input logic v, input logic [7:0] seq, input logic [71:0] p,
                       input logic [3:0] ic, input logic r, input logic c, input logic expect_out);
        @(negedge clk);
        rdy   = r;
        fv    = v;
        frame = {ic, seq, p};
        clr   = c;
        if (expect_out) exp_q.push_back({ic, p});
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] seq, input logic expect_out);
        cyc(1'b1, seq, pl(seq), seq[3:0], 1'b1, 1'b0, expect_out);
    endtask

    task automatic idle(input logic r);
        cyc(1'b0, 8'h00, 72'h0, 4'h0, r, 1'b0, 1'b0);
    endtask

    task automatic s_cyc(input logic v, input logic [7:0] seq, input logic c);
        @(negedge clk);
        s_rdy   = 1'b1;
        s_fv    = v;
        s_frame = {4'h0, seq, pl(seq)};
        s_clr   = c;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (payload_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_payload_valid: got payload %0h expected no strobe", payload_o);
            end else begin
                e = exp_q.pop_front();
                chk("payload", payload_o, e[71:0]);
                chk("icec", 72'(icec_o), 72'(e[75:72]));
            end
        end
        if (seq_err_o) seen_err++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000ns");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; rdy = 1'b0; fv = 1'b0; clr = 1'b0; frame = '0;
        s_rdy = 1'b0; s_fv = 1'b0; s_clr = 1'b0; s_frame = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 72'(link_state_o), 72'd0);
        chk("rst_payload", payload_o, 72'h0);
        chk("rst_icec", 72'(icec_o), 72'h0);
        chk("rst_err", 72'(err_cnt_o), 72'h0);
        chk("rst_locked", 72'(locked_o), 72'h0);
        @(negedge clk);
        rstn = 1'b1;

        // lock-up: 16 good frames
        idle(1'b1);
        chk("hunt_entry", 72'(link_state_o), 72'd1);
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0);
            if (i == 14) chk("hunt_15_frames", 72'(link_state_o), 72'd1);
        end
        chk("locked_16", 72'(link_state_o), 72'd2);
        chk("locked_o", 72'(locked_o), 72'd1);
        cyc(1'b1, 8'd16, 72'hA5, 4'h3, 1'b1, 1'b0, 1'b1);
        chk("first_payload", payload_o, 72'hA5);
        chk("first_valid", 72'(payload_valid_o), 72'd1);

        // legal 0xFF -> 0x00 wrap
        for (int s = 17; s < 256; s++) send(8'(s), 1'b1);
        send(8'h00, 1'b1);
        send(8'h01, 1'b1);
        chk("wrap_err_cnt", 72'(err_cnt_o), 72'd0);
        chk("wrap_seq_err", 72'(seq_err_o), 72'd0);

        // single sequence error
        for (int s = 2; s < 8'h30; s++) send(8'(s), 1'b1);
        send(8'h40, 1'b0);
        chk("bad_seq_err", 72'(seq_err_o), 72'd1);
        chk("bad_err_cnt", 72'(err_cnt_o), 72'd1);
        chk("bad_state", 72'(link_state_o), 72'd2);
        chk("bad_hold", payload_o, pl(8'h2F));
        send(8'h41, 1'b1);
        chk("resync_seq_err", 72'(seq_err_o), 72'd0);

        // four consecutive errors lose lock
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        chk("loss_3_state", 72'(link_state_o), 72'd2);
        send(8'h50, 1'b0);
        chk("loss_4_state", 72'(link_state_o), 72'd1);
        chk("loss_hold", payload_o, pl(8'h41));
        chk("loss_err_cnt", 72'(err_cnt_o), 72'd5);
        for (int s = 8'h51; s <= 8'h60; s++) send(8'(s), 1'b0);
        chk("relock_state", 72'(link_state_o), 72'd2);
        send(8'h61, 1'b1);

        // ready drop
        idle(1'b0);
        chk("drop_state", 72'(link_state_o), 72'd0);
        chk("drop_locked", 72'(locked_o), 72'd0);
        chk("drop_valid", 72'(payload_valid_o), 72'd0);
        chk("drop_hold", payload_o, pl(8'h61));
        idle(1'b1);
        for (int s = 0; s < 15; s++) send(8'(s), 1'b0);
        cyc(1'b1, 8'd15, pl(8'd15), 4'hF, 1'b0, 1'b0, 1'b0);
        chk("drop_wins_state", 72'(link_state_o), 72'd0);
        idle(1'b1);

        // clear coinciding with an error
        for (int s = 0; s < 16; s++) send(8'(s), 1'b0);
        chk("relock2_state", 72'(link_state_o), 72'd2);
        cyc(1'b1, 8'h99, pl(8'h99), 4'h9, 1'b1, 1'b1, 1'b0);
        chk("clr_with_err", 72'(err_cnt_o), 72'd1);
        cyc(1'b0, 8'h00, 72'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        chk("clr_only", 72'(err_cnt_o), 72'd0);
        chk("err_pulses", 72'(seen_err), 72'd6);

        // asynchronous reset mid-stream
        send(8'h9A, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_payload", payload_o, 72'h0);
        chk("arst_valid", 72'(payload_valid_o), 72'd0);
        chk("arst_icec", 72'(icec_o), 72'h0);
        chk("arst_state", 72'(link_state_o), 72'd0);
        chk("arst_locked", 72'(locked_o), 72'd0);
        chk("arst_err", 72'(err_cnt_o), 72'd0);
        @(negedge clk);
        rstn = 1'b1;
        fv   = 1'b0;

        // saturation on the 3-bit counter instance
        s_cyc(1'b0, 8'h00, 1'b0);
        s_cyc(1'b1, 8'h00, 1'b0);
        s_cyc(1'b1, 8'h01, 1'b0);
        chk("sat_locked", 72'(s_state), 72'd2);
        sx = 8'h02;
        for (int k = 0; k < 7; k++) begin
            s_cyc(1'b1, sx + 8'h10, 1'b0);
            s_cyc(1'b1, sx + 8'h11, 1'b0);
            sx = sx + 8'h12;
        end
        chk("sat_reach", 72'(s_err), 72'd7);
        s_cyc(1'b1, sx + 8'h10, 1'b0);
        chk("sat_hold", 72'(s_err), 72'd7);
        chk("sat_seq_err", 72'(s_seq_err), 72'd1);
        s_cyc(1'b1, sx + 8'h40, 1'b1);
        chk("sat_clr_err", 72'(s_err), 72'd1);
        chk("sat_still_locked", 72'(s_locked), 72'd1);

        idle(1'b1);
        idle(1'b1);
        chk("queue_drained", 72'(exp_q.size()), 72'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
